// File: rtl/csr_cmd_unit_pkg.sv
// Shared encodings for the WB-stage CSR command unit: opcodes, FSM states,
// CSR numbers and exception codes.
package csr_cmd_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_CSRRD   = 3'd1,
    OP_CSRWR   = 3'd2,
    OP_CSRXCHG = 3'd3,
    OP_ERTN    = 3'd4,
    OP_SYSCALL = 3'd5,
    OP_BREAK   = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ERTN = 2'd2
  } state_e;

  localparam logic [13:0] CSR_CRMD_NUM   = 14'h0;
  localparam logic [13:0] CSR_ERA_NUM    = 14'h6;
  localparam logic [13:0] CSR_EENTRY_NUM = 14'hC;
  localparam logic [13:0] CSR_SAVE0_NUM  = 14'h30;

  localparam logic [5:0] ECODE_INT = 6'h0;
  localparam logic [5:0] ECODE_SYS = 6'hB;
  localparam logic [5:0] ECODE_BRK = 6'hC;

  localparam logic [8:0] ESUBCODE_NONE = 9'h0;

  localparam logic [31:0] WMASK_ALL = 32'hFFFF_FFFF;

  // Ops that read the CSR port and hand the old value back to the GPR file.
  function automatic logic needsCsrAccess(input op_e op);
    return (op == OP_CSRRD) || (op == OP_CSRWR) || (op == OP_CSRXCHG);
  endfunction

endpackage

// File: rtl/csr_cmd_unit.sv
// WB-stage initiator for the CSR access / exception-commit port: one retiring
// instruction per handshake, producing GPR writeback and pre-IF redirects.
module csr_cmd_unit
  import csr_cmd_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [13:0] in_csr_num,
  input  logic [31:0] in_rd_value,
  input  logic [31:0] in_rj_value,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_vaddr,
  input  logic        in_ex,
  input  logic [5:0]  in_ecode,
  input  logic [8:0]  in_esubcode,
  input  logic        has_int,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  input  logic [31:0] ex_entry,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_e      state_q, state_d;
  op_e         inOp;
  logic        acceptEx, needsExec, accept;
  logic [5:0]  acceptEcode;
  logic [8:0]  acceptEsub;

  op_e         holdOp_q;
  logic [13:0] holdNum_q;
  logic [31:0] holdRd_q, holdRj_q, holdPc_q, holdVaddr_q, era_q;
  logic [4:0]  holdDest_q;
  logic        holdEx_q;
  logic [5:0]  holdEcode_q;
  logic [8:0]  holdEsub_q;

  logic        rfWe_q, redirValid_q;
  logic [4:0]  rfWaddr_q;
  logic [31:0] rfWdata_q, redirPc_q;

  assign inOp   = op_e'(in_op);
  assign accept = (state_q == S_IDLE) && in_valid;

  // Exception priority is resolved once at accept so EXEC only sees one cause.
  always_comb begin
    acceptEx    = 1'b1;
    acceptEcode = ECODE_INT;
    acceptEsub  = ESUBCODE_NONE;
    if (has_int) begin
      acceptEcode = ECODE_INT;
    end else if (in_ex) begin
      acceptEcode = in_ecode;
      acceptEsub  = in_esubcode;
    end else if (inOp == OP_SYSCALL) begin
      acceptEcode = ECODE_SYS;
    end else if (inOp == OP_BREAK) begin
      acceptEcode = ECODE_BRK;
    end else begin
      acceptEx = 1'b0;
    end
    needsExec = acceptEx || needsCsrAccess(inOp) || (inOp == OP_ERTN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && needsExec) state_d = S_EXEC;
      S_EXEC:  state_d = (!holdEx_q && holdOp_q == OP_ERTN) ? S_ERTN : S_IDLE;
      S_ERTN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == S_IDLE);
    csr_re      = 1'b0;
    csr_num     = '0;
    csr_we      = 1'b0;
    csr_wmask   = '0;
    csr_wvalue  = '0;
    wb_ex       = 1'b0;
    wb_ecode    = '0;
    wb_esubcode = '0;
    wb_pc       = '0;
    wb_vaddr    = '0;
    ertn_flush  = 1'b0;
    if (state_q == S_EXEC) begin
      if (holdEx_q) begin
        wb_ex       = 1'b1;
        wb_ecode    = holdEcode_q;
        wb_esubcode = holdEsub_q;
        wb_pc       = holdPc_q;
        wb_vaddr    = holdVaddr_q;
      end else begin
        case (holdOp_q)
          OP_CSRRD: begin
            csr_re  = 1'b1;
            csr_num = holdNum_q;
          end
          OP_CSRWR, OP_CSRXCHG: begin
            csr_re     = 1'b1;
            csr_num    = holdNum_q;
            csr_we     = 1'b1;
            csr_wmask  = (holdOp_q == OP_CSRWR) ? WMASK_ALL : holdRj_q;
            csr_wvalue = holdRd_q;
          end
          OP_ERTN: begin
            csr_re  = 1'b1;
            csr_num = CSR_ERA_NUM;
          end
          default: ;
        endcase
      end
    end else if (state_q == S_ERTN) begin
      ertn_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      holdOp_q    <= OP_NOP;
      holdNum_q   <= '0;
      holdRd_q    <= '0;
      holdRj_q    <= '0;
      holdDest_q  <= '0;
      holdPc_q    <= '0;
      holdVaddr_q <= '0;
      holdEx_q    <= 1'b0;
      holdEcode_q <= '0;
      holdEsub_q  <= '0;
    end else if (accept) begin
      holdOp_q    <= inOp;
      holdNum_q   <= in_csr_num;
      holdRd_q    <= in_rd_value;
      holdRj_q    <= in_rj_value;
      holdDest_q  <= in_dest;
      holdPc_q    <= in_pc;
      holdVaddr_q <= in_vaddr;
      holdEx_q    <= acceptEx;
      holdEcode_q <= acceptEcode;
      holdEsub_q  <= acceptEsub;
    end
  end

  // rf_we and redirect_valid default low every cycle so they stay single pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rfWe_q       <= 1'b0;
      rfWaddr_q    <= '0;
      rfWdata_q    <= '0;
      redirValid_q <= 1'b0;
      redirPc_q    <= '0;
      era_q        <= '0;
    end else begin
      rfWe_q       <= 1'b0;
      redirValid_q <= 1'b0;
      case (state_q)
        S_EXEC: begin
          if (holdEx_q) begin
            redirValid_q <= 1'b1;
            redirPc_q    <= ex_entry;
          end else if (needsCsrAccess(holdOp_q)) begin
            rfWe_q    <= (holdDest_q != 5'd0);
            rfWaddr_q <= holdDest_q;
            rfWdata_q <= csr_rvalue;
          end else if (holdOp_q == OP_ERTN) begin
            era_q <= csr_rvalue;
          end
        end
        S_ERTN: begin
          redirValid_q <= 1'b1;
          redirPc_q    <= era_q;
        end
        default: ;
      endcase
    end
  end

  assign rf_we          = rfWe_q;
  assign rf_waddr       = rfWaddr_q;
  assign rf_wdata       = rfWdata_q;
  assign redirect_valid = redirValid_q;
  assign redirect_pc    = redirPc_q;

endmodule

// File: tb/tb_csr_cmd_unit.sv
// Directed, table-driven bench for csr_cmd_unit with a tiny CSR file model
// (SAVE0 at 0x30, ERA at 0x6) answering the combinational read port.
module tb_csr_cmd_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rd_value, in_rj_value, in_pc, in_vaddr;
  logic [4:0]  in_dest;
  logic        in_ex;
  logic [5:0]  in_ecode;
  logic [8:0]  in_esubcode;
  logic        has_int;
  logic        csr_re, csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue, csr_wmask, csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush;
  logic [31:0] ex_entry;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_cmd_unit dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_csr_num(in_csr_num), .in_rd_value(in_rd_value), .in_rj_value(in_rj_value),
    .in_dest(in_dest), .in_pc(in_pc), .in_vaddr(in_vaddr),
    .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode),
    .has_int(has_int),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .ex_entry(ex_entry),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // CSR file model: preloaded through loadCsr, otherwise applies masked writes.
  logic        loadCsr = 1'b0;
  logic [31:0] loadSave0, loadEra;
  logic [31:0] save0, eraReg;

  always @(posedge clk) begin
    if (loadCsr) begin
      save0  <= loadSave0;
      eraReg <= loadEra;
    end else if (csr_we) begin
      if (csr_num == 14'h30) save0 <= (save0 & ~csr_wmask) | (csr_wvalue & csr_wmask);
      else if (csr_num == 14'h6) eraReg <= (eraReg & ~csr_wmask) | (csr_wvalue & csr_wmask);
    end
  end

  always_comb begin
    csr_rvalue = 32'h0;
    if (csr_num == 14'h30)     csr_rvalue = save0;
    else if (csr_num == 14'h6) csr_rvalue = eraReg;
  end

  typedef struct {
    logic [2:0]  op;
    logic [13:0] num;
    logic [31:0] rd, rj;
    logic [4:0]  dest;
    logic [31:0] pc, vaddr;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        hasInt;
    logic [31:0] save0Init, eraInit, entry;
    logic        expCsrRe;
    logic [13:0] expCsrNum;
    logic        expCsrWe;
    logic [31:0] expWmask, expWvalue;
    logic        expWbEx;
    logic [5:0]  expEcode;
    logic [8:0]  expEsub;
    logic [31:0] expWbPc, expWbVaddr;
    logic        expErtn;
    logic        expRfWe;
    logic [4:0]  expRfWaddr;
    logic [31:0] expRfWdata;
    logic        expRedir;
    logic [31:0] expRedirPc;
    logic [31:0] expSave0;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  task automatic clearInputs();
    in_valid = 1'b0; in_op = 3'd0; in_csr_num = '0; in_rd_value = '0; in_rj_value = '0;
    in_dest = '0; in_pc = '0; in_vaddr = '0; in_ex = 1'b0; in_ecode = '0; in_esubcode = '0;
    has_int = 1'b0;
  endtask

  task automatic preload(input logic [31:0] s0, input logic [31:0] era);
    @(negedge clk);
    loadCsr = 1'b1; loadSave0 = s0; loadEra = era;
    @(negedge clk);
    loadCsr = 1'b0;
  endtask

  task automatic applyStimulus(input int i, input vec_t v);
    preload(v.save0Init, v.eraInit);
    in_valid = 1'b1; in_op = v.op; in_csr_num = v.num; in_rd_value = v.rd; in_rj_value = v.rj;
    in_dest = v.dest; in_pc = v.pc; in_vaddr = v.vaddr; in_ex = v.ex; in_ecode = v.ecode;
    in_esubcode = v.esub; has_int = v.hasInt; ex_entry = v.entry;
    #1 checkOutput("accept.in_ready", i, in_ready, 1'b1);
    @(negedge clk);
    clearInputs();
    checkOutput("exec.in_ready", i, in_ready, 1'b0);
    checkOutput("exec.csr_re", i, csr_re, v.expCsrRe);
    checkOutput("exec.csr_num", i, csr_num, v.expCsrNum);
    checkOutput("exec.csr_we", i, csr_we, v.expCsrWe);
    if (v.expCsrWe) begin
      checkOutput("exec.csr_wmask", i, csr_wmask, v.expWmask);
      checkOutput("exec.csr_wvalue", i, csr_wvalue, v.expWvalue);
    end
    checkOutput("exec.wb_ex", i, wb_ex, v.expWbEx);
    if (v.expWbEx) begin
      checkOutput("exec.wb_ecode", i, wb_ecode, v.expEcode);
      checkOutput("exec.wb_esubcode", i, wb_esubcode, v.expEsub);
      checkOutput("exec.wb_pc", i, wb_pc, v.expWbPc);
      checkOutput("exec.wb_vaddr", i, wb_vaddr, v.expWbVaddr);
    end
    checkOutput("exec.ertn_flush", i, ertn_flush, 1'b0);
    checkOutput("exec.rf_we", i, rf_we, 1'b0);
    checkOutput("exec.redirect_valid", i, redirect_valid, 1'b0);
    if (v.expErtn) begin
      @(negedge clk);
      checkOutput("ertn.ertn_flush", i, ertn_flush, 1'b1);
      checkOutput("ertn.in_ready", i, in_ready, 1'b0);
      checkOutput("ertn.csr_re", i, csr_re, 1'b0);
      checkOutput("ertn.redirect_valid", i, redirect_valid, 1'b0);
    end
    @(negedge clk);
    checkOutput("done.in_ready", i, in_ready, 1'b1);
    checkOutput("done.rf_we", i, rf_we, v.expRfWe);
    if (v.expRfWe) begin
      checkOutput("done.rf_waddr", i, rf_waddr, v.expRfWaddr);
      checkOutput("done.rf_wdata", i, rf_wdata, v.expRfWdata);
    end
    checkOutput("done.redirect_valid", i, redirect_valid, v.expRedir);
    if (v.expRedir) checkOutput("done.redirect_pc", i, redirect_pc, v.expRedirPc);
    checkOutput("done.wb_ex", i, wb_ex, 1'b0);
    checkOutput("done.ertn_flush", i, ertn_flush, 1'b0);
    checkOutput("done.csr_we", i, csr_we, 1'b0);
    @(negedge clk);
    checkOutput("after.rf_we", i, rf_we, 1'b0);
    checkOutput("after.redirect_valid", i, redirect_valid, 1'b0);
    checkOutput("after.save0", i, save0, v.expSave0);
  endtask

  initial begin
    //           op     num     rd            rj            dest  pc            vaddr         ex    ecode  esub  int   save0Init     eraInit       entry
    //           re     num     we    wmask         wvalue        wbEx  ecode  esub  wbPc          wbVaddr       ertn  rfWe  waddr wdata         redir redirPc       save0
    vecs[0]  = '{3'd1, 14'h30, 32'h0,        32'h0,        5'd3, 32'h1c000000, 32'h0,        1'b0, 6'h0,  9'h0, 1'b0, 32'h1234,     32'h0,        32'h0,
                 1'b1, 14'h30, 1'b0, 32'h0,        32'h0,        1'b0, 6'h0,  9'h0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd3, 32'h1234,     1'b0, 32'h0,        32'h1234};
    vecs[1]  = '{3'd3, 14'h30, 32'hFFFF0000, 32'h00FF00FF, 5'd5, 32'h1c000004, 32'h0,        1'b0, 6'h0,  9'h0, 1'b0, 32'h1234,     32'h0,        32'h0,
                 1'b1, 14'h30, 1'b1, 32'h00FF00FF, 32'hFFFF0000, 1'b0, 6'h0,  9'h0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd5, 32'h1234,     1'b0, 32'h0,        32'h00FF1200};
    vecs[2]  = '{3'd2, 14'h30, 32'hA5A5A5A5, 32'hDEADBEEF, 5'd7, 32'h1c000008, 32'h0,        1'b0, 6'h0,  9'h0, 1'b0, 32'h00FF1200, 32'h0,        32'h0,
                 1'b1, 14'h30, 1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0, 6'h0,  9'h0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd7, 32'h00FF1200, 1'b0, 32'h0,        32'hA5A5A5A5};
    vecs[3]  = '{3'd1, 14'h30, 32'h0,        32'h0,        5'd0, 32'h1c00000c, 32'h0,        1'b0, 6'h0,  9'h0, 1'b0, 32'h55AA,     32'h0,        32'h0,
                 1'b1, 14'h30, 1'b0, 32'h0,        32'h0,        1'b0, 6'h0,  9'h0, 32'h0,        32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h55AA};
    vecs[4]  = '{3'd5, 14'h0,  32'h0,        32'h0,        5'd0, 32'h1c000100, 32'h11110000, 1'b0, 6'h0,  9'h0, 1'b0, 32'h0,        32'h0,        32'h1c008000,
                 1'b0, 14'h0,  1'b0, 32'h0,        32'h0,        1'b1, 6'hB,  9'h0, 32'h1c000100, 32'h11110000, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h1c008000, 32'h0};
    vecs[5]  = '{3'd6, 14'h0,  32'h0,        32'h0,        5'd2, 32'h1c000200, 32'h0,        1'b0, 6'h0,  9'h0, 1'b0, 32'h9,        32'h0,        32'h1c008040,
                 1'b0, 14'h0,  1'b0, 32'h0,        32'h0,        1'b1, 6'hC,  9'h0, 32'h1c000200, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h1c008040, 32'h9};
    vecs[6]  = '{3'd2, 14'h30, 32'hFFFFFFFF, 32'h0,        5'd4, 32'h1c000300, 32'h0,        1'b0, 6'h0,  9'h0, 1'b1, 32'h77,       32'h0,        32'h1c008000,
                 1'b0, 14'h0,  1'b0, 32'h0,        32'h0,        1'b1, 6'h0,  9'h0, 32'h1c000300, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h1c008000, 32'h77};
    vecs[7]  = '{3'd1, 14'h30, 32'h0,        32'h0,        5'd9, 32'h1c000400, 32'hDEADBEEF, 1'b1, 6'h8,  9'h1, 1'b0, 32'h4242,     32'h0,        32'h1c009000,
                 1'b0, 14'h0,  1'b0, 32'h0,        32'h0,        1'b1, 6'h8,  9'h1, 32'h1c000400, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h1c009000, 32'h4242};
    vecs[8]  = '{3'd5, 14'h0,  32'h0,        32'h0,        5'd0, 32'h1c000500, 32'h0,        1'b1, 6'h9,  9'h2, 1'b0, 32'h0,        32'h0,        32'h1c008000,
                 1'b0, 14'h0,  1'b0, 32'h0,        32'h0,        1'b1, 6'h9,  9'h2, 32'h1c000500, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h1c008000, 32'h0};
    vecs[9]  = '{3'd4, 14'h0,  32'h0,        32'h0,        5'd0, 32'h1c000600, 32'h0,        1'b1, 6'h10, 9'h3, 1'b1, 32'h0,        32'h1c000104, 32'h1c008000,
                 1'b0, 14'h0,  1'b0, 32'h0,        32'h0,        1'b1, 6'h0,  9'h0, 32'h1c000600, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h1c008000, 32'h0};
    vecs[10] = '{3'd4, 14'h0,  32'h0,        32'h0,        5'd0, 32'h1c000700, 32'h0,        1'b0, 6'h0,  9'h0, 1'b0, 32'h0,        32'h1c000104, 32'h0,
                 1'b1, 14'h6,  1'b0, 32'h0,        32'h0,        1'b0, 6'h0,  9'h0, 32'h0,        32'h0,        1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 32'h1c000104, 32'h0};
    vecs[11] = '{3'd3, 14'h30, 32'h12345678, 32'h0000FFFF, 5'd0, 32'h1c000800, 32'h0,        1'b0, 6'h0,  9'h0, 1'b0, 32'hABCD0000, 32'h0,        32'h0,
                 1'b1, 14'h30, 1'b1, 32'h0000FFFF, 32'h12345678, 1'b0, 6'h0,  9'h0, 32'h0,        32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'hABCD5678};

    clearInputs();
    ex_entry = 32'h0;
    loadSave0 = 32'h0;
    loadEra = 32'h0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset.in_ready", -1, in_ready, 1'b1);
    checkOutput("reset.csr_re", -1, csr_re, 1'b0);
    checkOutput("reset.csr_num", -1, csr_num, 32'h0);
    checkOutput("reset.csr_we", -1, csr_we, 1'b0);
    checkOutput("reset.csr_wmask", -1, csr_wmask, 32'h0);
    checkOutput("reset.csr_wvalue", -1, csr_wvalue, 32'h0);
    checkOutput("reset.wb_ex", -1, wb_ex, 1'b0);
    checkOutput("reset.wb_pc", -1, wb_pc, 32'h0);
    checkOutput("reset.ertn_flush", -1, ertn_flush, 1'b0);
    checkOutput("reset.rf_we", -1, rf_we, 1'b0);
    checkOutput("reset.rf_wdata", -1, rf_wdata, 32'h0);
    checkOutput("reset.redirect_valid", -1, redirect_valid, 1'b0);
    checkOutput("reset.redirect_pc", -1, redirect_pc, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) applyStimulus(i, vecs[i]);

    // NOP without exception is accepted and leaves the unit in IDLE.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_dest = 5'd3;
    @(negedge clk);
    clearInputs();
    checkOutput("nop.in_ready", 100, in_ready, 1'b1);
    checkOutput("nop.csr_re", 100, csr_re, 1'b0);
    checkOutput("nop.wb_ex", 100, wb_ex, 1'b0);
    @(negedge clk);
    checkOutput("nop.rf_we", 100, rf_we, 1'b0);
    checkOutput("nop.redirect_valid", 100, redirect_valid, 1'b0);

    // Reset asserted mid-EXEC of a CSRWR: strobes drop at once, nothing commits.
    preload(32'hCAFE, 32'h0);
    in_valid = 1'b1; in_op = 3'd2; in_csr_num = 14'h30; in_rd_value = 32'h1111; in_dest = 5'd6;
    @(negedge clk);
    clearInputs();
    checkOutput("rst.exec_csr_we", 101, csr_we, 1'b1);
    resetn = 1'b0;
    #1;
    checkOutput("rst.csr_we", 101, csr_we, 1'b0);
    checkOutput("rst.csr_re", 101, csr_re, 1'b0);
    checkOutput("rst.csr_num", 101, csr_num, 32'h0);
    checkOutput("rst.in_ready", 101, in_ready, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rst.rf_we", 101, rf_we, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst.post_in_ready", 101, in_ready, 1'b1);
    checkOutput("rst.post_rf_we", 101, rf_we, 1'b0);
    checkOutput("rst.post_csr_re", 101, csr_re, 1'b0);
    checkOutput("rst.save0", 101, save0, 32'hCAFE);

    // Unit must be fully usable after the mid-operation reset.
    applyStimulus(102, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_cmd_unit.md
Name: csr_cmd_unit

Overview:
- WB-stage initiator for the CSR file's access and exception-commit port.
- Accepts one retiring instruction per handshake from MEM and sequences the CSR port: read, write or mask-write, exception commit, or ERTN.
- Produces the GPR writeback for CSR instructions and the pipeline redirect (exception entry or ERA) to pre-IF.

Parameters:
- CSR_ERA_NUM, 14'h6, CSR number read to get the ERTN return address.
- ECODE_INT, 6'h0, ecode committed for an interrupt.
- ECODE_SYS, 6'hB, ecode committed for SYSCALL.
- ECODE_BRK, 6'hC, ecode committed for BREAK.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  MEM offers an instruction
- in_ready  out  1  unit can accept
- in_op  in  3  0 NOP, 1 CSRRD, 2 CSRWR, 3 CSRXCHG, 4 ERTN, 5 SYSCALL, 6 BREAK
- in_csr_num  in  14  CSR index
- in_rd_value  in  32  write data (old rd value)
- in_rj_value  in  32  CSRXCHG write mask
- in_dest  in  5  GPR destination
- in_pc  in  32  instruction PC
- in_vaddr  in  32  faulting data address
- in_ex  in  1  earlier-stage exception pending
- in_ecode  in  6  earlier-stage ecode
- in_esubcode  in  9  earlier-stage esubcode
- has_int  in  1  interrupt pending from CSR file
- csr_re  out  1  CSR read enable
- csr_num  out  14  CSR index
- csr_rvalue  in  32  CSR read data, combinational
- csr_we  out  1  CSR write enable
- csr_wmask  out  32  CSR write mask
- csr_wvalue  out  32  CSR write value
- wb_ex  out  1  exception commit pulse
- wb_ecode  out  6  exception ecode
- wb_esubcode  out  9  exception esubcode
- wb_pc  out  32  exception PC
- wb_vaddr  out  32  exception vaddr
- ertn_flush  out  1  ERTN commit pulse
- ex_entry  in  32  exception entry address
- rf_we  out  1  GPR write strobe, registered
- rf_waddr  out  5  GPR address, registered
- rf_wdata  out  32  GPR data, registered
- redirect_valid  out  1  pre-IF redirect pulse, registered
- redirect_pc  out  32  redirect target, registered

Behaviour:
- FSM states: IDLE, EXEC, ERTN. Reset state is IDLE.
- Reset values: every output is 0, except in_ready, which is 1.
- Reset is asynchronous. Asserting it mid-operation drops all strobes and holding registers immediately, with no partial commit.
- IDLE:
  - in_ready=1.
  - When in_valid=1, latch all in_* fields plus the has_int sample into holding registers and go to EXEC.
  - When in_op=NOP and there is no exception or interrupt, accept and stay in IDLE.
- Exception priority at accept: has_int (ECODE_INT, esubcode 0) > in_ex (in_ecode/in_esubcode) > SYSCALL > BREAK.
  - A pending exception suppresses any CSR access or ERTN.
- EXEC (in_ready=0), exception case:
  - Drive wb_ex=1 for exactly one cycle, with wb_ecode, wb_esubcode, wb_pc=held pc, wb_vaddr=held vaddr.
  - The next edge sets redirect_valid=1 and redirect_pc=ex_entry (value sampled this cycle). Return to IDLE.
- EXEC, CSRRD:
  - csr_re=1, csr_num=held num.
  - Next edge: rf_we=1, rf_waddr=dest, rf_wdata=csr_rvalue. Return to IDLE.
- EXEC, CSRWR:
  - Same read as CSRRD, plus csr_we=1, csr_wmask=32'hFFFFFFFF, csr_wvalue=held rd_value, in the same cycle.
  - rf receives the pre-write value.
- EXEC, CSRXCHG: as CSRWR, but csr_wmask=held rj_value.
- EXEC, ERTN: csr_re=1, csr_num=CSR_ERA_NUM. Capture csr_rvalue into an internal era register. Go to ERTN.
- ERTN state:
  - ertn_flush=1 for one cycle.
  - Next edge: redirect_valid=1, redirect_pc=captured era. Return to IDLE.
- rf_we is forced to 0 when dest=0.
- rf_we and redirect_valid are one-cycle pulses.
- When no access is active: csr_re, csr_we, wb_ex and ertn_flush are 0, and csr_num, csr_wmask and csr_wvalue are 0.
- Latency from accept edge to rf/redirect pulse: CSR op 2 cycles; exception 2 cycles; ERTN 3 cycles.
- Throughput: one instruction per 2 cycles (3 for ERTN); in_ready is low in EXEC and ERTN.

Decomposition:
- Shared package: op encodings (NOP…BREAK), ECODE_*/ESUBCODE constants, CSR number constants (ERA, CRMD, EENTRY…), state encodings.
- No sub-module; one FSM plus holding registers in a single module.

Test Plan:
- CSRRD num 0x30 (SAVE0=0x1234): rf_we pulse 2 cycles after accept, rf_wdata=0x1234, csr_we=0 throughout.
- CSRXCHG num 0x30, rd=0xFFFF0000, rj=0x00FF00FF, dest=5: csr_wmask=0x00FF00FF, csr_wvalue=0xFFFF0000; rf_wdata=old value; SAVE0 becomes (old&~mask)|0x00FF0000.
- SYSCALL pc=0x1c000100, ex_entry=0x1c008000: wb_ex single pulse with ecode 0xB, wb_pc=0x1c000100; redirect_pc=0x1c008000 next cycle; no rf_we.
- CSRWR with has_int=1 at accept: wb_ex with ecode 0, csr_we never asserted.
- ERTN with ERA=0x1c000104: csr_num=0x6 in EXEC, ertn_flush pulse in ERTN state, redirect_pc=0x1c000104 one cycle later, in_ready low for 2 cycles.
- resetn deasserted while in EXEC for a CSRWR: csr_we drops immediately, no rf_we; after release in_ready=1 and state IDLE.
